key8_debounce_latch: RTL and testbench

//  Upstream front end for the 8-input one-hot to 7-segment encoder.
//  - Takes 8 raw, asynchronous push-button lines and synchronises each one.
//  - Debounces each line independently.
//  - Latches the most recently pressed key as a registered one-hot byte.
//  - onehot[7] drives encoder input A and onehot[0] drives input H, so the

---
 rtl/key8_pkg.sv | 22 ++
 rtl/key_debounce.sv | 60 ++++++
 rtl/key8_debounce_latch.sv | 75 +++++++
 tb/tb_key8_debounce_latch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/key8_pkg.sv
// Shared constants and helpers for the 8-key debounce/latch front end.
package key8_pkg;

  localparam int NUM_KEYS           = 8;
  localparam int KEY_IDX_W          = 3;
  localparam int DEB_CYCLES_DEFAULT = 500000;

  typedef logic [NUM_KEYS-1:0]  key_vec_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  // Index of the highest set bit; the upper keys win when several are
  // pressed together. Returns 0 for an all-zero vector.
  function automatic key_idx_t highestIndex(input key_vec_t vec);
    key_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button line: two-flop synchroniser, stability counter,
// debounced level flop and a rising-edge press pulse.
module key_debounce
  import key8_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has disagreed with the current one on
  // DEB_CYCLES consecutive edges; any agreement throws the count away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the level, used to spot the press edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level_d <= 1'b0;
    else     r_level_d <= r_level;
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/key8_debounce_latch.sv
// Front end for the one-hot 7-segment encoder: debounces eight buttons and
// latches the most recently pressed one as a registered one-hot byte.
module key8_debounce_latch
  import key8_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  key_in,
  input  logic                 clr,
  output logic [NUM_KEYS-1:0]  onehot,
  output logic [KEY_IDX_W-1:0] key_idx,
  output logic                 valid,
  output logic                 key_event,
  output logic [NUM_KEYS-1:0]  key_level
);

  key_vec_t w_level;
  key_vec_t w_press;
  key_idx_t w_sel_idx;
  key_vec_t w_sel_onehot;

  key_vec_t r_onehot;
  key_idx_t r_key_idx;
  logic     r_valid;
  logic     r_key_event;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_line
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_key  (key_in[g]),
      .o_level(w_level[g]),
      .o_press(w_press[g])
    );
  end

  // Pick the highest-numbered key among those pressed this cycle.
  always_comb begin
    w_sel_idx    = highestIndex(w_press);
    w_sel_onehot = key_vec_t'(1) << w_sel_idx;
  end

  // Output latch: a clear wins over a simultaneous press, a press replaces
  // the latched key, releases leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot    <= '0;
      r_key_idx   <= '0;
      r_valid     <= 1'b0;
      r_key_event <= 1'b0;
    end else if (clr) begin
      r_onehot    <= '0;
      r_valid     <= 1'b0;
      r_key_event <= 1'b0;
    end else if (|w_press) begin
      r_onehot    <= w_sel_onehot;
      r_key_idx   <= w_sel_idx;
      r_valid     <= 1'b1;
      r_key_event <= 1'b1;
    end else begin
      r_key_event <= 1'b0;
    end
  end

  assign onehot    = r_onehot;
  assign key_idx   = r_key_idx;
  assign valid     = r_valid;
  assign key_event = r_key_event;
  assign key_level = w_level;

endmodule

// File: tb/tb_key8_debounce_latch.sv
// Directed bench for key8_debounce_latch with a short debounce window.
// Edge 1 is the first rising edge after key_in (or rst) changes.
module tb_key8_debounce_latch;

  localparam int DEB = 4;

  typedef struct {
    string      tag;
    logic [7:0] onehot;
    logic [2:0] idx;
    logic       valid;
    logic       ev;
    logic [7:0] level;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic       clr;
  logic [7:0] onehot;
  logic [2:0] key_idx;
  logic       valid;
  logic       key_event;
  logic [7:0] key_level;

  exp_t expQ[$];
  int   totalCount = 0;
  int   passCount  = 0;
  int   evCount    = 0;
  int   evBase     = 0;

  key8_debounce_latch #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .clr      (clr),
    .onehot   (onehot),
    .key_idx  (key_idx),
    .valid    (valid),
    .key_event(key_event),
    .key_level(key_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count event pulses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (key_event === 1'b1) evCount++;
  end

  task automatic cmp(input string tag, input string fld,
                     input logic [7:0] obs, input logic [7:0] expv);
    totalCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] oh,
                               input logic [2:0] idx, input logic v,
                               input logic ev, input logic [7:0] lvl);
    exp_t e;
    e.tag = tag; e.onehot = oh; e.idx = idx; e.valid = v; e.ev = ev; e.level = lvl;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      totalCount++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = expQ.pop_front();
    cmp(e.tag, "onehot",    onehot,           e.onehot);
    cmp(e.tag, "key_idx",   8'(key_idx),      8'(e.idx));
    cmp(e.tag, "valid",     8'(valid),        8'(e.valid));
    cmp(e.tag, "key_event", 8'(key_event),    8'(e.ev));
    cmp(e.tag, "key_level", key_level,        e.level);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1. Reset with random buttons: outputs clear straight away.
    rst = 1'b1; clr = 1'b0; key_in = 8'($urandom);
    #1;
    applyStimulus("rst_async", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00); checkOutput();
    tick(2);
    rst = 1'b0; key_in = 8'h00;
    applyStimulus("rst_after", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    tick(1); checkOutput();

    // 2. Clean press of key 2.
    evBase = evCount; key_in = 8'h04;
    applyStimulus("press_e5", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    tick(5); checkOutput();
    applyStimulus("press_e6", 8'h00, 3'd0, 1'b0, 1'b0, 8'h04);
    tick(1); checkOutput();
    applyStimulus("press_e7", 8'h04, 3'd2, 1'b1, 1'b1, 8'h04);
    tick(1); checkOutput();
    applyStimulus("press_e8", 8'h04, 3'd2, 1'b1, 1'b0, 8'h04);
    tick(1); checkOutput();
    tick(4);
    cmp("press", "events", 8'(evCount - evBase), 8'd1);
    key_in = 8'h00;
    applyStimulus("release2", 8'h04, 3'd2, 1'b1, 1'b0, 8'h00);
    tick(8); checkOutput();

    // 3. Glitch on key 5 shorter than the window.
    evBase = evCount; key_in = 8'h20;
    tick(3);
    key_in = 8'h00;
    applyStimulus("glitch", 8'h04, 3'd2, 1'b1, 1'b0, 8'h00);
    tick(10); checkOutput();
    cmp("glitch", "events", 8'(evCount - evBase), 8'd0);

    // 4. Keys 6 and 1 together: key 6 wins.
    evBase = evCount; key_in = 8'h42;
    applyStimulus("simul_e6", 8'h04, 3'd2, 1'b1, 1'b0, 8'h42);
    tick(6); checkOutput();
    applyStimulus("simul_e7", 8'h40, 3'd6, 1'b1, 1'b1, 8'h42);
    tick(1); checkOutput();
    applyStimulus("simul_hold", 8'h40, 3'd6, 1'b1, 1'b0, 8'h42);
    tick(5); checkOutput();
    cmp("simul", "events", 8'(evCount - evBase), 8'd1);

    // 5. Release, clear, then a clear landing on key 3's press edge.
    evBase = evCount; key_in = 8'h00;
    applyStimulus("release6", 8'h40, 3'd6, 1'b1, 1'b0, 8'h00);
    tick(8); checkOutput();
    clr = 1'b1;
    applyStimulus("clear", 8'h00, 3'd6, 1'b0, 1'b0, 8'h00);
    tick(1); checkOutput();
    clr = 1'b0; key_in = 8'h08;
    applyStimulus("clrpress_e6", 8'h00, 3'd6, 1'b0, 1'b0, 8'h08);
    tick(6); checkOutput();
    clr = 1'b1;
    applyStimulus("clrpress_e7", 8'h00, 3'd6, 1'b0, 1'b0, 8'h08);
    tick(1); checkOutput();
    clr = 1'b0;
    applyStimulus("clrpress_hold", 8'h00, 3'd6, 1'b0, 1'b0, 8'h08);
    tick(4); checkOutput();
    cmp("clear", "events", 8'(evCount - evBase), 8'd0);

    // 6. Reset in the middle of key 1's debounce window.
    key_in = 8'h00;
    tick(8);
    evBase = evCount; key_in = 8'h02;
    tick(3);
    rst = 1'b1;
    #1;
    applyStimulus("midrst_async", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00); checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("midrst_e6", 8'h00, 3'd0, 1'b0, 1'b0, 8'h02);
    tick(6); checkOutput();
    applyStimulus("midrst_e7", 8'h02, 3'd1, 1'b1, 1'b1, 8'h02);
    tick(1); checkOutput();
    tick(3);
    cmp("midrst", "events", 8'(evCount - evBase), 8'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
